// File: rtl/fft_pkg.sv
// Shared types and helpers for the streaming FFT butterfly stages.
// Widths vary per instance, so samples are carried at MAX_W and narrowed by the caller.
package fft_pkg;

    localparam int MAX_W = 32;

    typedef logic signed [MAX_W-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    typedef struct packed {
        cplx_t sum;
        cplx_t diff;
    } cplx_pair_t;

    typedef enum logic {
        PH_STORE   = 1'b0,
        PH_COMPUTE = 1'b1
    } phase_t;

    // Index width for a counter or pointer spanning 'depth' entries (never below 1).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Treat the low w bits of x as a signed value and widen it to MAX_W.
    function automatic sample_t sext(input logic [MAX_W-1:0] x, input int w);
        sample_t t;
        t = sample_t'(x << (MAX_W - w));
        return t >>> (MAX_W - w);
    endfunction

    // Full-precision a+b (sub=0) or a-b (sub=1) of two w-bit signed operands.
    function automatic sample_t sext_addsub(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input int w,
                                            input logic sub);
        sample_t sa;
        sample_t sb;
        sa = sext(a, w);
        sb = sext(b, w);
        return sub ? (sa - sb) : (sa + sb);
    endfunction

endpackage

// File: rtl/fft_beat_delay.sv
// D-deep circular buffer of whole beats; writes on store beats, reads on compute beats.
// Deep buffers use an unreset RAM array, shallow ones plain registers.
module fft_beat_delay
    import fft_pkg::*;
#(
    parameter int WIDTH = 288,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);

    localparam int D_W = idx_w(DEPTH);
    localparam logic [D_W-1:0] PTR_LAST = D_W'(DEPTH - 1);

    logic [D_W-1:0] wr_ptr_q;
    logic [D_W-1:0] wr_ptr_d;
    logic [D_W-1:0] rd_ptr_q;
    logic [D_W-1:0] rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + D_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + D_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    if (DEPTH > 4) begin : g_ram
        logic [WIDTH-1:0] mem [DEPTH];

        // Entries are always written before they are read, so no reset is needed.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr_q] <= wr_data;
            end
        end

        assign rd_data = mem[rd_ptr_q];
    end else begin : g_regs
        logic [WIDTH-1:0] regs_q [DEPTH];
        logic [WIDTH-1:0] regs_d [DEPTH];

        always_comb begin
            regs_d = regs_q;
            if (wr_en) begin
                regs_d[wr_ptr_q] = wr_data;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    regs_q[i] <= '0;
                end
            end else begin
                regs_q <= regs_d;
            end
        end

        assign rd_data = regs_q[rd_ptr_q];
    end

endmodule

// File: rtl/fft_bfly_stage.sv
// Radix-2 DIF butterfly stage: pairs sample n with n+SPAN through a beat-delay buffer
// and registers the full-precision sum and difference of every lane.
module fft_bfly_stage
    import fft_pkg::*;
#(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = IN_WIDTH + 1,
    parameter int NUM       = 16,
    parameter int DATA      = 512,
    parameter int SPAN      = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM*IN_WIDTH-1:0]  din_i,
    input  logic [NUM*IN_WIDTH-1:0]  din_q,
    input  logic                     valid_in,
    output logic [NUM*OUT_WIDTH-1:0] do1_re,
    output logic [NUM*OUT_WIDTH-1:0] do1_im,
    output logic [NUM*OUT_WIDTH-1:0] do2_re,
    output logic [NUM*OUT_WIDTH-1:0] do2_im,
    output logic                     valid_out,
    output logic                     sof_out,
    output logic                     eof_out
);

    localparam int D      = SPAN / NUM;
    localparam int BEATS  = DATA / NUM;
    localparam int HALF   = BEATS / 2;
    localparam int BEAT_W = idx_w(BEATS);
    localparam int OCNT_W = idx_w(HALF);
    localparam int PH_BIT = $clog2(D);
    localparam int VEC_W  = NUM * IN_WIDTH;
    localparam int OVEC_W = NUM * OUT_WIDTH;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(HALF - 1);

    logic [BEAT_W-1:0] beat_cnt_q;
    logic [BEAT_W-1:0] beat_cnt_d;
    logic [OCNT_W-1:0] out_cnt_q;
    logic [OCNT_W-1:0] out_cnt_d;
    phase_t            phase;
    logic              store_beat;
    logic              compute_beat;
    logic [2*VEC_W-1:0] head;

    logic [OVEC_W-1:0] sum_re;
    logic [OVEC_W-1:0] sum_im;
    logic [OVEC_W-1:0] dif_re;
    logic [OVEC_W-1:0] dif_im;

    logic [OVEC_W-1:0] do1_re_q;
    logic [OVEC_W-1:0] do1_re_d;
    logic [OVEC_W-1:0] do1_im_q;
    logic [OVEC_W-1:0] do1_im_d;
    logic [OVEC_W-1:0] do2_re_q;
    logic [OVEC_W-1:0] do2_re_d;
    logic [OVEC_W-1:0] do2_im_q;
    logic [OVEC_W-1:0] do2_im_d;
    logic              valid_out_q;
    logic              valid_out_d;
    logic              sof_out_q;
    logic              sof_out_d;
    logic              eof_out_q;
    logic              eof_out_d;

    // Within each 2*D-beat block the first D beats are stored, the next D are paired.
    assign phase        = phase_t'(beat_cnt_q[PH_BIT]);
    assign store_beat   = valid_in && (phase == PH_STORE);
    assign compute_beat = valid_in && (phase == PH_COMPUTE);

    fft_beat_delay #(
        .WIDTH (2 * VEC_W),
        .DEPTH (D)
    ) u_delay (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (store_beat),
        .wr_data ({din_q, din_i}),
        .rd_en   (compute_beat),
        .rd_data (head)
    );

    // Lane k occupies bits [k*W +: W] of every packed vector.
    for (genvar k = 0; k < NUM; k++) begin : g_lane
        logic [MAX_W-1:0] a_re;
        logic [MAX_W-1:0] a_im;
        logic [MAX_W-1:0] b_re;
        logic [MAX_W-1:0] b_im;

        assign a_re = MAX_W'(head[k*IN_WIDTH +: IN_WIDTH]);
        assign a_im = MAX_W'(head[VEC_W + k*IN_WIDTH +: IN_WIDTH]);
        assign b_re = MAX_W'(din_i[k*IN_WIDTH +: IN_WIDTH]);
        assign b_im = MAX_W'(din_q[k*IN_WIDTH +: IN_WIDTH]);

        assign sum_re[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sext_addsub(a_re, b_re, IN_WIDTH, 1'b0));
        assign sum_im[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sext_addsub(a_im, b_im, IN_WIDTH, 1'b0));
        assign dif_re[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sext_addsub(a_re, b_re, IN_WIDTH, 1'b1));
        assign dif_im[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sext_addsub(a_im, b_im, IN_WIDTH, 1'b1));
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        out_cnt_d   = out_cnt_q;
        do1_re_d    = do1_re_q;
        do1_im_d    = do1_im_q;
        do2_re_d    = do2_re_q;
        do2_im_d    = do2_im_q;
        valid_out_d = 1'b0;
        sof_out_d   = 1'b0;
        eof_out_d   = 1'b0;

        if (valid_in) begin
            beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BEAT_W'(1);
        end

        if (compute_beat) begin
            out_cnt_d   = (out_cnt_q == OCNT_LAST) ? '0 : out_cnt_q + OCNT_W'(1);
            do1_re_d    = sum_re;
            do1_im_d    = sum_im;
            do2_re_d    = dif_re;
            do2_im_d    = dif_im;
            valid_out_d = 1'b1;
            sof_out_d   = (out_cnt_q == '0);
            eof_out_d   = (out_cnt_q == OCNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q  <= '0;
            out_cnt_q   <= '0;
            do1_re_q    <= '0;
            do1_im_q    <= '0;
            do2_re_q    <= '0;
            do2_im_q    <= '0;
            valid_out_q <= 1'b0;
            sof_out_q   <= 1'b0;
            eof_out_q   <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            out_cnt_q   <= out_cnt_d;
            do1_re_q    <= do1_re_d;
            do1_im_q    <= do1_im_d;
            do2_re_q    <= do2_re_d;
            do2_im_q    <= do2_im_d;
            valid_out_q <= valid_out_d;
            sof_out_q   <= sof_out_d;
            eof_out_q   <= eof_out_d;
        end
    end

    assign do1_re    = do1_re_q;
    assign do1_im    = do1_im_q;
    assign do2_re    = do2_re_q;
    assign do2_im    = do2_im_q;
    assign valid_out = valid_out_q;
    assign sof_out   = sof_out_q;
    assign eof_out   = eof_out_q;

endmodule
